// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-aligned word commit and leading-zero blanking.
// Latency: every output is registered; a load shows up on load_ack one cycle later and on the display at the next frame wrap.
// Backpressure: none; every load is accepted, and the last load before a wrap wins.
module seg_scan_ctrl #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] bcd_in,
   input  logic        blank_lz,
   output logic        load_ack,
   output logic        pend_valid,
   output logic [3:0]  DIGIT,
   output logic [3:0]  value,
   output logic        frame_done
);

   // Terminal count of the per-digit prescaler.
   localparam logic [15:0] TC_VAL = 16'(SCAN_DIV - 1);

   logic [15:0] presc;
   logic [1:0]  idx;
   logic [15:0] active;
   logic [15:0] pending;

   logic        tc;
   logic        wrap;
   logic [1:0]  idx_nxt;
   logic [15:0] active_nxt;
   logic [3:0]  digit_nxt;
   logic [3:0]  value_nxt;

   // Next-state view of the scan position and the committed word, so that
   // DIGIT and value are registered from the same values on the same edge.
   always_comb begin
      tc         = (presc == TC_VAL);
      wrap       = tc && (idx == 2'd3);
      idx_nxt    = tc ? idx + 2'd1 : idx;
      active_nxt = active;
      if (wrap) begin
         if (load)
            active_nxt = bcd_in;       // load on the wrap edge bypasses pending
         else if (pend_valid)
            active_nxt = pending;
      end
   end

   // Digit select and blanked value for the digit that will be lit next cycle.
   always_comb begin
      digit_nxt = 4'b1110;
      value_nxt = active_nxt[3:0];
      case (idx_nxt)
         2'd0: begin
            digit_nxt = 4'b1110;
            value_nxt = active_nxt[3:0];   // digit 0 is never blanked
         end
         2'd1: begin
            digit_nxt = 4'b1101;
            value_nxt = (blank_lz && active_nxt[15:4] == 12'h000) ? 4'hF : active_nxt[7:4];
         end
         2'd2: begin
            digit_nxt = 4'b1011;
            value_nxt = (blank_lz && active_nxt[15:8] == 8'h00) ? 4'hF : active_nxt[11:8];
         end
         default: begin
            digit_nxt = 4'b0111;
            value_nxt = (blank_lz && active_nxt[15:12] == 4'h0) ? 4'hF : active_nxt[15:12];
         end
      endcase
   end

   // Prescaler, scan index, word buffering and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc      <= 16'h0000;
         idx        <= 2'd0;
         active     <= 16'h0000;
         pending    <= 16'h0000;
         pend_valid <= 1'b0;
         DIGIT      <= 4'b1110;
         value      <= 4'h0;
         load_ack   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         presc      <= tc ? 16'h0000 : presc + 16'h0001;
         idx        <= idx_nxt;
         active     <= active_nxt;
         DIGIT      <= digit_nxt;
         value      <= value_nxt;
         load_ack   <= load;
         frame_done <= wrap;
         if (load)
            pending <= bcd_in;
         if (wrap)
            pend_valid <= 1'b0;
         else if (load)
            pend_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed display scenarios plus random loads, checked every cycle against a reference model.
// The model tracks edges since reset, the displayed word and an optional pending word.
// Inputs are driven at the falling edge; outputs are sampled at the falling edge.
module tb_seg_scan_ctrl;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] bcd_in;
   logic        blank_lz;
   logic        load_ack;
   logic        pend_valid;
   logic [3:0]  DIGIT;
   logic [3:0]  value;
   logic        frame_done;

   seg_scan_ctrl #(.SCAN_DIV(DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .bcd_in     (bcd_in),
      .blank_lz   (blank_lz),
      .load_ack   (load_ack),
      .pend_valid (pend_valid),
      .DIGIT      (DIGIT),
      .value      (value),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   int          m_n;        // clock edges since reset release
   logic [15:0] m_shown;    // word currently committed to the display
   logic [15:0] m_pend;
   logic        m_pv;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, m_n);
   endtask

   function automatic logic [3:0] exp_val(input logic [15:0] w, input int d, input logic blz);
      logic [15:0] hi;
      hi = w >> (4 * d);
      if (blz && d > 0 && hi == 16'h0000)
         return 4'hF;
      return hi[3:0];
   endfunction

   task automatic model_reset();
      m_n     = 0;
      m_shown = 16'h0000;
      m_pend  = 16'h0000;
      m_pv    = 1'b0;
   endtask

   // One clock: drive inputs, let the edge happen, then compare all outputs.
   task automatic step(input logic ld, input logic [15:0] d, input logic blz);
      logic wrap;
      int   dig;
      load     = ld;
      bcd_in   = d;
      blank_lz = blz;
      @(posedge clk);
      m_n++;
      wrap = (m_n % FRAME == 0);
      if (wrap) begin
         if (ld)
            m_shown = d;
         else if (m_pv)
            m_shown = m_pend;
         m_pv = 1'b0;
      end else if (ld) begin
         m_pend = d;
         m_pv   = 1'b1;
      end
      @(negedge clk);
      dig = (m_n / DIV) % 4;
      chk("digit",      {12'h0, DIGIT},      {12'h0, ~(4'b0001 << dig)});
      chk("value",      {12'h0, value},      {12'h0, exp_val(m_shown, dig, blz)});
      chk("pend_valid", {15'h0, pend_valid}, {15'h0, m_pv});
      chk("load_ack",   {15'h0, load_ack},   {15'h0, ld});
      chk("frame_done", {15'h0, frame_done}, {15'h0, wrap});
   endtask

   task automatic idle(input int cycles, input logic blz);
      for (int i = 0; i < cycles; i++)
         step(1'b0, 16'h0000, blz);
   endtask

   // Idle until the edge count since reset reaches the given phase within a frame.
   task automatic idle_to_phase(input int phase, input logic blz);
      for (int i = 0; i < FRAME && (m_n % FRAME) != phase; i++)
         step(1'b0, 16'h0000, blz);
   endtask

   initial begin
      rst      = 1'b1;
      load     = 1'b0;
      bcd_in   = 16'h0000;
      blank_lz = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_digit", {12'h0, DIGIT}, 16'h000E);
      chk("rst_value", {12'h0, value}, 16'h0000);
      rst = 1'b0;

      // Plain scan of 1234: load, commit at the wrap, then two full frames.
      step(1'b1, 16'h1234, 1'b0);
      idle_to_phase(0, 1'b0);
      chk("commit_1234", {12'h0, value}, 16'h0004);
      idle(2 * FRAME, 1'b0);

      // Tear-free load while digit 1 is lit.
      idle_to_phase(DIV, 1'b0);
      step(1'b1, 16'h5678, 1'b0);
      chk("tearfree_pv", {15'h0, pend_valid}, 16'h0001);
      idle_to_phase(0, 1'b0);
      chk("tearfree_d0", {12'h0, value}, 16'h0008);
      idle(FRAME, 1'b0);

      // Last load in a frame wins.
      idle_to_phase(2, 1'b0);
      step(1'b1, 16'h1111, 1'b0);
      idle(3, 1'b0);
      step(1'b1, 16'h2222, 1'b0);
      idle_to_phase(0, 1'b0);
      idle(FRAME, 1'b0);

      // Load exactly on the wrap edge bypasses pending.
      idle_to_phase(FRAME - 1, 1'b0);
      step(1'b1, 16'h9999, 1'b0);
      chk("bypass_val", {12'h0, value},      16'h0009);
      chk("bypass_pv",  {15'h0, pend_valid}, 16'h0000);
      idle(FRAME, 1'b0);

      // Leading-zero blanking cases.
      step(1'b1, 16'h0050, 1'b1);
      idle_to_phase(0, 1'b1);
      idle(FRAME, 1'b1);
      step(1'b1, 16'h0000, 1'b1);
      idle_to_phase(0, 1'b1);
      idle(FRAME, 1'b1);
      step(1'b1, 16'h0050, 1'b0);
      idle_to_phase(0, 1'b0);
      idle(FRAME, 1'b0);

      // Reset mid-scan at digit 2 with a load in flight; pending word must be dropped.
      idle_to_phase(2 * DIV, 1'b0);
      step(1'b1, 16'h4321, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_digit", {12'h0, DIGIT},      16'h000E);
      chk("midrst_value", {12'h0, value},      16'h0000);
      chk("midrst_pv",    {15'h0, pend_valid}, 16'h0000);
      chk("midrst_ack",   {15'h0, load_ack},   16'h0000);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      idle(2 * FRAME, 1'b0);

      // Random traffic: sparse loads, words biased toward zero nibbles, live blanking toggles.
      for (int i = 0; i < 3000; i++) begin
         logic        ld;
         logic [15:0] w;
         logic [15:0] mask;
         logic        blz;
         ld   = ($urandom_range(0, 7) == 0);
         mask = {{4{1'($urandom_range(0, 1))}}, {4{1'($urandom_range(0, 1))}},
                 {4{1'($urandom_range(0, 1))}}, {4{1'($urandom_range(0, 1))}}};
         w    = 16'($urandom) & mask;
         blz  = ((i / 200) % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         step(ld, w, blz);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
